// File: rtl/unified_memory_responder.sv
// rtl/unified_memory_responder.sv - shared instruction/data memory responder with wait states
//
// Purpose: one-request-at-a-time memory behind the core's unified port. A request is
// accepted in IDLE, held for WAIT_CYCLES wait states, then answered with a single-cycle
// ready pulse carrying extended load data (or err). Stores merge byte lanes into the
// addressed word on the clock edge that ends the response cycle.
//
// Optional build macro: MEM_ALIGN_CHECK_EN
//   defined   - misaligned half/word accesses return err and do not write
//   undefined - misaligned accesses are forced down to natural alignment and proceed
//
// Ports:
//   i_clk      system clock, rising edge
//   i_reset    asynchronous active-high reset
//   i_req      request valid, sampled only in IDLE
//   i_we       1 = store, 0 = load/fetch
//   i_addr     byte address; word index wraps modulo MEM_WORDS
//   i_wdata    right-aligned store data
//   i_funct3   access size / extension
//   o_rdata    extended load data while o_ready, else 0
//   o_ready    one-cycle completion pulse
//   o_err      illegal or misaligned access, valid with o_ready

module unified_memory_responder #(
    parameter int MEM_WORDS   = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_rdata,
    output logic        o_ready,
    output logic        o_err
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam logic [3:0] LP_WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t        r_state;
    logic [3:0]    r_cnt;
    logic          r_we;
    logic [AW+1:0] r_addr;
    logic [31:0]   r_wdata;
    logic [2:0]    r_funct3;
    logic [31:0]   r_rdata;
    logic          r_ready;
    logic          r_err;
    logic          r_wr_en;
    logic [AW-1:0] r_wr_idx;
    logic [31:0]   r_wr_data;
    logic [31:0]   r_mem [MEM_WORDS];

    // With zero wait states the response is decoded in the same cycle the request is
    // accepted, so decode from the live inputs in IDLE and from the latched copy otherwise.
    logic          w_we;
    logic [AW+1:0] w_addr;
    logic [31:0]   w_wdata;
    logic [2:0]    w_funct3;
    logic [1:0]    w_size;
    logic          w_illegal;
    logic          w_misal;
    logic          w_err;
    logic [1:0]    w_lo;
    logic [AW-1:0] w_idx;
    logic [31:0]   w_word;
    logic [31:0]   w_shifted;
    logic [31:0]   w_load;
    logic [31:0]   w_mask;
    logic [31:0]   w_merged;

    always_comb begin
        w_we      = (r_state == S_IDLE) ? i_we            : r_we;
        w_addr    = (r_state == S_IDLE) ? i_addr[AW+1:0]  : r_addr;
        w_wdata   = (r_state == S_IDLE) ? i_wdata         : r_wdata;
        w_funct3  = (r_state == S_IDLE) ? i_funct3        : r_funct3;
        w_size    = w_funct3[1:0];
        // 011/111 have no size; 110 and unsigned stores (100/101 with we) are not accesses.
        w_illegal = (w_size == 2'b11) || (w_funct3[2] && (w_we || w_size == 2'b10));
        w_misal   = ((w_size == 2'b01) && w_addr[0]) ||
                    ((w_size == 2'b10) && (w_addr[1:0] != 2'b00));
`ifdef MEM_ALIGN_CHECK_EN
        w_lo      = w_addr[1:0];
        w_err     = w_illegal || w_misal;
`else
        if (w_size == 2'b01)
            w_lo = {w_addr[1], 1'b0};
        else if (w_size == 2'b10)
            w_lo = 2'b00;
        else
            w_lo = w_addr[1:0];
        w_err     = w_illegal;
`endif
        w_idx     = w_addr[AW+1:2];
        w_word    = r_mem[w_idx];
        w_shifted = w_word >> {w_lo, 3'b000};
        case (w_funct3)
            3'b000:  w_load = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'b001:  w_load = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b010:  w_load = w_word;
            3'b100:  w_load = {24'd0, w_shifted[7:0]};
            3'b101:  w_load = {16'd0, w_shifted[15:0]};
            default: w_load = 32'd0;
        endcase
        case (w_size)
            2'b00:   w_mask = 32'h0000_00FF << {w_lo, 3'b000};
            2'b01:   w_mask = 32'h0000_FFFF << {w_lo, 3'b000};
            default: w_mask = 32'hFFFF_FFFF;
        endcase
        w_merged  = (w_word & ~w_mask) | ((w_wdata << {w_lo, 3'b000}) & w_mask);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= 32'd0;
            r_funct3  <= 3'd0;
            r_rdata   <= 32'd0;
            r_ready   <= 1'b0;
            r_err     <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_idx  <= '0;
            r_wr_data <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ready <= 1'b0;
                    r_err   <= 1'b0;
                    r_rdata <= 32'd0;
                    r_wr_en <= 1'b0;
                    if (i_req) begin
                        r_we     <= i_we;
                        r_addr   <= i_addr[AW+1:0];
                        r_wdata  <= i_wdata;
                        r_funct3 <= i_funct3;
                        r_cnt    <= LP_WAIT_LOAD;
                        if (WAIT_CYCLES > 0) begin
                            r_state <= S_WAIT;
                        end else begin
                            r_state <= S_RESP;
                            r_ready <= 1'b1;
                            r_err   <= w_err;
                            r_rdata <= (w_err || w_we) ? 32'd0 : w_load;
                            r_wr_en <= w_we && !w_err;
                        end
                        r_wr_idx  <= w_idx;
                        r_wr_data <= w_merged;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state   <= S_RESP;
                        r_ready   <= 1'b1;
                        r_err     <= w_err;
                        r_rdata   <= (w_err || w_we) ? 32'd0 : w_load;
                        r_wr_en   <= w_we && !w_err;
                        r_wr_idx  <= w_idx;
                        r_wr_data <= w_merged;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b0;
                    r_err   <= 1'b0;
                    r_rdata <= 32'd0;
                    r_wr_en <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b0;
                    r_err   <= 1'b0;
                    r_rdata <= 32'd0;
                    r_wr_en <= 1'b0;
                end
            endcase
        end
    end

    // Array is never cleared; an async reset clears r_wr_en and so drops a pending store.
    always_ff @(posedge i_clk) begin
        if (r_wr_en && (r_state == S_RESP))
            r_mem[r_wr_idx] <= r_wr_data;
    end

    assign o_rdata = r_rdata;
    assign o_ready = r_ready;
    assign o_err   = r_err;

endmodule

// File: tb/tb_unified_memory_responder.sv
// tb/tb_unified_memory_responder.sv - scoreboard bench for unified_memory_responder

module tb_unified_memory_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req   [3];
    logic        we    [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [2:0]  f3    [3];
    logic [31:0] rdata [3];
    logic        rdy   [3];
    logic        err   [3];

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int          d;
        logic [31:0] rd;
        logic        er;
        int          at;
    } exp_t;
    exp_t sb[$];

`ifdef MEM_ALIGN_CHECK_EN
    localparam logic [31:0] W20_AFTER_SH = 32'h1122_AA44;
`else
    localparam logic [31:0] W20_AFTER_SH = 32'h7777_AA44;
`endif

    // instance 0: 2 wait states, instance 1: 3, instance 2: 0
    function automatic int wc(int d);
        return (d == 0) ? 2 : ((d == 1) ? 3 : 0);
    endfunction

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            unified_memory_responder #(
                .MEM_WORDS  (1024),
                .WAIT_CYCLES((g == 0) ? 2 : ((g == 1) ? 3 : 0))
            ) u_dut (
                .i_clk   (clk),
                .i_reset (rst),
                .i_req   (req[g]),
                .i_we    (we[g]),
                .i_addr  (addr[g]),
                .i_wdata (wdata[g]),
                .i_funct3(f3[g]),
                .o_rdata (rdata[g]),
                .o_ready (rdy[g]),
                .o_err   (err[g])
            );
        end
    endgenerate

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Every ready pulse must match the oldest outstanding expectation, including its cycle.
    always @(negedge clk) begin
        if (!rst) begin
            for (int g = 0; g < 3; g++) begin
                if (rdy[g]) begin
                    if (sb.size() == 0) begin
                        check("spurious_ready", 32'(g), 32'hFFFF_FFFF);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check("dut_id", 32'(g), 32'(e.d));
                        check("rdata", rdata[g], e.rd);
                        check("err", {31'd0, err[g]}, {31'd0, e.er});
                        check("latency", 32'(cyc), 32'(e.at));
                    end
                end
            end
        end
    end

    // Called at a negedge; request is sampled at the following posedge.
    task automatic send(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [2:0] fn, input logic [31:0] erd, input logic eerr,
                        input bit expect_resp);
        if (expect_resp)
            sb.push_back(exp_t'{d, erd, eerr, cyc + 1 + wc(d)});
        req[d]   = 1'b1;
        we[d]    = w;
        addr[d]  = a;
        wdata[d] = wd;
        f3[d]    = fn;
        @(negedge clk);
        req[d] = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("timeout_pending", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic ld(input int d, input logic [31:0] a, input logic [2:0] fn,
                      input logic [31:0] exp_rd, input logic exp_err);
        send(d, 1'b0, a, 32'd0, fn, exp_rd, exp_err, 1'b1);
        drain();
    endtask

    task automatic st(input int d, input logic [31:0] a, input logic [31:0] wd,
                      input logic [2:0] fn, input logic exp_err);
        send(d, 1'b1, a, wd, fn, 32'd0, exp_err, 1'b1);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "global timeout");
    end

    initial begin
        for (int g = 0; g < 3; g++) begin
            req[g] = 1'b0; we[g] = 1'b0; addr[g] = 32'd0; wdata[g] = 32'd0; f3[g] = 3'b010;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int g = 0; g < 3; g++) begin
            check("reset_ready", {31'd0, rdy[g]}, 32'd0);
            check("reset_err", {31'd0, err[g]}, 32'd0);
            check("reset_rdata", rdata[g], 32'd0);
        end
        @(negedge clk);

        // reset during WAIT drops the store
        st(1, 32'h10, 32'd0, 3'b010, 1'b0);
        send(1, 1'b1, 32'h10, 32'hDEAD_BEEF, 3'b010, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("reset_mid_wait_ready", {31'd0, rdy[1]}, 32'd0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        ld(1, 32'h10, 3'b010, 32'd0, 1'b0);

        // zero wait states
        st(2, 32'h40, 32'h0000_0055, 3'b010, 1'b0);
        ld(2, 32'h40, 3'b010, 32'h0000_0055, 1'b0);

        // byte lanes and extension
        st(0, 32'h20, 32'h1122_3344, 3'b010, 1'b0);
        st(0, 32'h21, 32'h0000_00AA, 3'b000, 1'b0);
        ld(0, 32'h20, 3'b010, 32'h1122_AA44, 1'b0);
        ld(0, 32'h21, 3'b000, 32'hFFFF_FFAA, 1'b0);
        ld(0, 32'h21, 3'b100, 32'h0000_00AA, 1'b0);
        ld(0, 32'h22, 3'b001, 32'h0000_1122, 1'b0);
        ld(0, 32'h20, 3'b001, 32'hFFFF_AA44, 1'b0);
        ld(0, 32'h20, 3'b101, 32'h0000_AA44, 1'b0);

        // address wrap
        st(0, 32'h0000_1004, 32'hCAFE_F00D, 3'b010, 1'b0);
        ld(0, 32'h4, 3'b010, 32'hCAFE_F00D, 1'b0);

        // misalignment
`ifdef MEM_ALIGN_CHECK_EN
        ld(0, 32'h22, 3'b010, 32'd0, 1'b1);
        st(0, 32'h23, 32'h0000_7777, 3'b001, 1'b1);
`else
        ld(0, 32'h22, 3'b010, 32'h1122_AA44, 1'b0);
        st(0, 32'h23, 32'h0000_7777, 3'b001, 1'b0);
`endif
        ld(0, 32'h20, 3'b010, W20_AFTER_SH, 1'b0);

        // illegal funct3
        st(0, 32'h20, 32'd0, 3'b100, 1'b1);
        st(0, 32'h20, 32'd0, 3'b110, 1'b1);
        ld(0, 32'h20, 3'b011, 32'd0, 1'b1);
        ld(0, 32'h20, 3'b111, 32'd0, 1'b1);
        ld(0, 32'h20, 3'b010, W20_AFTER_SH, 1'b0);

        // back-to-back with req held across RESP; address changes while waiting
        sb.push_back(exp_t'{0, 32'hCAFE_F00D, 1'b0, cyc + 3});
        sb.push_back(exp_t'{0, W20_AFTER_SH, 1'b0, cyc + 7});
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h4; f3[0] = 3'b010;
        repeat (2) @(negedge clk);
        addr[0] = 32'h20;
        repeat (3) @(negedge clk);
        req[0] = 1'b0;
        drain();
        check("idle_rdata", rdata[0], 32'd0);
        check("idle_ready", {31'd0, rdy[0]}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/unified_memory_responder.md
Name: unified_memory_responder

Overview:
Memory-side responder for the multicycle RISC-V core's single shared instruction/data port. It accepts one request at a time (fetch, load or store), inserts a configurable number of wait states, then returns a one-cycle ready pulse with read data. Loads are byte/half/word sized and sign- or zero-extended per funct3. Stores use byte lanes. The control unit stalls in FETCH/MEMORY_ACCESS until ready.

Parameters:
MEM_WORDS, 1024, storage depth in 32-bit words; power of two, ≥4
WAIT_CYCLES, 1, extra cycles between request acceptance and ready (0..15)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
req  input  1  request valid; sampled only in IDLE
we  input  1  1 = store, 0 = load/fetch; held stable with req
addr  input  32  byte address; word index = addr[log2(MEM_WORDS)+1:2], upper bits ignored (wrap)
wdata  input  32  store data, right-aligned (SB uses [7:0], SH uses [15:0])
funct3  input  3  access size/extension; core drives 010 for fetch
rdata  output  32  extended load data, valid only while ready=1, else 0
ready  output  1  one-cycle completion pulse
err  output  1  asserted with ready on misaligned/illegal access

Behaviour:
- Reset (async, any state): state←IDLE, ready=0, err=0, rdata=0, wait counter=0. Any pending store is dropped. Array contents are not cleared.
- States: IDLE, WAIT, RESP.
- IDLE: if req=1, latch we/addr/wdata/funct3. Next state is WAIT if WAIT_CYCLES>0, else RESP. Counter loads WAIT_CYCLES-1.
- WAIT: counter decrements each cycle; at 0 go to RESP. req/inputs are ignored (latched copy used).
- RESP: ready=1 for exactly this cycle, rdata/err valid. The store commits at the rising edge ending RESP. Next state is always IDLE.
- Latency: req seen at edge N → ready high in cycle N+1+WAIT_CYCLES.
- Back-to-back: req held high in the cycle after RESP is accepted as a new request. Max throughput is one access per WAIT_CYCLES+2 cycles.
- Load funct3:
  - 000 LB: sign-extend byte addr[1:0]
  - 001 LH: sign-extend half addr[1]
  - 010 LW: full word
  - 100 LBU: zero-extend byte
  - 101 LHU: zero-extend half
- Store funct3: 000 SB lane addr[1:0]; 001 SH lanes addr[1]*2..+1; 010 SW all lanes. Unwritten lanes are preserved.
- Illegal funct3 (011, 110, 111; or 100/101 with we=1): err=1, rdata=0, no write.
- Misaligned (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]≠0): err=1, rdata=0, no write.
- Address beyond MEM_WORDS wraps modulo depth; this is not an error.
- rdata reflects array contents at RESP. A store in RESP is visible to the next request.

Optional Feature:
MEM_ALIGN_CHECK_EN:
- Defined: misalignment is reported as above.
- Undefined: misaligned accesses do not raise err. Low address bits are forced down to natural alignment (half: addr[0]=0; word: addr[1:0]=0) and the access proceeds normally. Illegal-funct3 err remains in both builds.

Test Plan:
- Reset mid-WAIT: WAIT_CYCLES=3, SW addr 0x10 wdata 0xDEADBEEF, assert reset during WAIT → no ready; LW 0x10 afterwards returns the prior value (0 after preload).
- Latency: WAIT_CYCLES=2, req at edge 0 → ready exactly in cycle 3 only. Repeat with WAIT_CYCLES=0 → ready in cycle 1.
- Byte-lane store/load: SW 0x20=0x11223344; SB 0x21 wdata 0xAA → LW 0x20 = 0x1122AA44; LB 0x21 = 0xFFFFFFAA; LBU 0x21 = 0x000000AA; LH 0x22 = 0x00001122.
- Wrap: MEM_WORDS=1024, SW 0x0000_1004=0xCAFEF00D → LW 0x4 = 0xCAFEF00D, err=0.
- Misaligned: LW 0x22 → err=1, rdata=0 (macro on). Macro off → returns word at 0x20, err=0. SH 0x23 with macro on leaves memory unchanged.
- Illegal/back-to-back: LBU with we=1 (funct3=100) → err=1, no write. Next, req held high across RESP for two LW requests → two ready pulses WAIT_CYCLES+2 cycles apart.
